// File: rtl/systolic_drain.sv
// Double-banked output serializer: parallel-loads a result matrix from the PE
// array and streams it out row-major, one word per cycle, on valid/yumi.
module systolic_drain #(
  parameter int width_p        = 8,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2
) (
  input  logic                                              clk_i,
  input  logic                                              reset_i,
  input  logic                                              en_i,
  input  logic                                              flush_i,
  input  logic                                              load_i,
  input  logic [array_width_p*array_height_p*width_p-1:0]   z_i,
  output logic                                              ready_o,
  output logic                                              valid_o,
  output logic [width_p-1:0]                                data_o,
  output logic                                              last_o,
  input  logic                                              yumi_i,
  output logic                                              dropped_o
);

  // state    | meaning
  // st_empty | no bank holds an undrained matrix
  // st_one   | one bank draining (or waiting), the other free
  // st_full  | both banks hold matrices, loads are refused
  typedef enum logic [1:0] {st_empty = 2'd0, st_one = 2'd1, st_full = 2'd2} state_e;

  localparam int n_lp     = array_width_p * array_height_p;
  localparam int idx_w_lp = (n_lp > 1) ? $clog2(n_lp) : 1;
  localparam logic [idx_w_lp-1:0] idx_last_lp = idx_w_lp'(n_lp - 1);

  logic [width_p-1:0]  bank_r [2][n_lp];
  state_e              state_r, state_n;
  logic                wr_bank_r, wr_bank_n;
  logic                rd_bank_r, rd_bank_n;
  logic [idx_w_lp-1:0] idx_r, idx_n;
  logic                dropped_r, dropped_n;
  logic                load_acc, pop, final_pop, clear;

  assign clear     = reset_i | flush_i;
  assign ready_o   = en_i & (state_r != st_full);
  assign valid_o   = en_i & (state_r != st_empty);
  assign data_o    = bank_r[rd_bank_r][idx_r];
  assign last_o    = valid_o & (idx_r == idx_last_lp);
  assign dropped_o = dropped_r;

  assign load_acc  = load_i & ready_o;
  assign pop       = yumi_i & valid_o;
  assign final_pop = pop & (idx_r == idx_last_lp);

  always_comb begin
    state_n   = state_r;
    wr_bank_n = wr_bank_r ^ load_acc;
    rd_bank_n = rd_bank_r ^ final_pop;
    idx_n     = idx_r;
    dropped_n = dropped_r | (en_i & load_i & ~ready_o);

    if (pop) begin
      idx_n = final_pop ? '0 : idx_r + 1'b1;
    end

    // A load landing on the final pop keeps the occupancy unchanged.
    case ({load_acc, final_pop})
      2'b10: begin
        case (state_r)
          st_empty: state_n = st_one;
          st_one:   state_n = st_full;
          default:  state_n = st_full;
        endcase
      end
      2'b01: begin
        case (state_r)
          st_full: state_n = st_one;
          st_one:  state_n = st_empty;
          default: state_n = st_empty;
        endcase
      end
      default: state_n = state_r;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clear) begin
      state_r   <= st_empty;
      wr_bank_r <= 1'b0;
      rd_bank_r <= 1'b0;
      idx_r     <= '0;
      dropped_r <= 1'b0;
    end else if (en_i) begin
      state_r   <= state_n;
      wr_bank_r <= wr_bank_n;
      rd_bank_r <= rd_bank_n;
      idx_r     <= idx_n;
      dropped_r <= dropped_n;
    end
  end

  // Bank storage is deliberately left out of reset; only the pointers matter.
  always_ff @(posedge clk_i) begin
    if (!clear && load_acc) begin
      for (int i = 0; i < n_lp; i++) begin
        bank_r[wr_bank_r][i] <= z_i[i*width_p +: width_p];
      end
    end
  end

endmodule

// File: tb/tb_systolic_drain.sv
// Directed table-driven bench for systolic_drain (2x2, 8-bit words).
module tb_systolic_drain;

  logic        clk_i = 1'b0;
  logic        reset_i, en_i, flush_i, load_i, yumi_i;
  logic [31:0] z_i;
  logic        ready_o, valid_o, last_o, dropped_o;
  logic [7:0]  data_o;

  int total = 0;
  int bad   = 0;

  systolic_drain #(.width_p(8), .array_width_p(2), .array_height_p(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .flush_i(flush_i),
    .load_i(load_i), .z_i(z_i), .ready_o(ready_o), .valid_o(valid_o),
    .data_o(data_o), .last_o(last_o), .yumi_i(yumi_i), .dropped_o(dropped_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        en, flush, load, yumi;
    logic [31:0] z;
    logic        ev, er, el, ed, cd;
    logic [7:0]  d;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic en, logic fl, logic ld, logic yu, logic [31:0] z,
                              logic ev, logic er, logic el, logic ed, logic cd, logic [7:0] d);
    vec_t v;
    v.en = en; v.flush = fl; v.load = ld; v.yumi = yu; v.z = z;
    v.ev = ev; v.er = er; v.el = el; v.ed = ed; v.cd = cd; v.d = d;
    return v;
  endfunction

  task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d actual=%0h required=%0h", name, row, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic en, logic fl, logic ld, logic yu, logic [31:0] z);
    @(negedge clk_i);
    reset_i = rst; en_i = en; flush_i = fl; load_i = ld; yumi_i = yu; z_i = z;
    #1;
  endtask

  initial begin
    reset_i = 1'b1; en_i = 1'b1; flush_i = 1'b0; load_i = 1'b0; yumi_i = 1'b0; z_i = '0;

    // basic drain
    tbl.push_back(mk(1,0,1,0,32'h44332211, 0,1,0,0,0,8'h00));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,1,0,0,1,8'h11));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,1,0,0,1,8'h22));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,1,0,0,1,8'h33));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,1,1,0,1,8'h44));
    tbl.push_back(mk(1,0,0,0,32'h0,        0,1,0,0,0,8'h00));
    // two banks full, third load dropped, gapless stream
    tbl.push_back(mk(1,0,1,0,32'h04030201, 0,1,0,0,0,8'h00));
    tbl.push_back(mk(1,0,1,0,32'h08070605, 1,1,0,0,1,8'h01));
    tbl.push_back(mk(1,0,1,0,32'hCCCCCCCC, 1,0,0,0,1,8'h01));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,0,0,1,1,8'h01));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,0,0,1,1,8'h02));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,0,0,1,1,8'h03));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,0,1,1,1,8'h04));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,1,0,1,1,8'h05));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,1,0,1,1,8'h06));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,1,0,1,1,8'h07));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,1,1,1,1,8'h08));
    tbl.push_back(mk(1,1,0,0,32'h0,        0,1,0,1,0,8'h00));
    // load on the final pop of the draining matrix
    tbl.push_back(mk(1,0,1,0,32'h14131211, 0,1,0,0,0,8'h00));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,1,0,0,1,8'h11));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,1,0,0,1,8'h12));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,1,0,0,1,8'h13));
    tbl.push_back(mk(1,0,1,1,32'h24232221, 1,1,1,0,1,8'h14));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,1,0,0,1,8'h21));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,1,0,0,1,8'h22));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,1,0,0,1,8'h23));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,1,1,0,1,8'h24));
    tbl.push_back(mk(1,0,0,0,32'h0,        0,1,0,0,0,8'h00));
    // yumi toggling and enable low mid-drain
    tbl.push_back(mk(1,0,1,0,32'h34333231, 0,1,0,0,0,8'h00));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,1,0,0,1,8'h31));
    tbl.push_back(mk(1,0,0,0,32'h0,        1,1,0,0,1,8'h32));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,1,0,0,1,8'h32));
    tbl.push_back(mk(1,0,0,0,32'h0,        1,1,0,0,1,8'h33));
    tbl.push_back(mk(0,0,1,1,32'hEEEEEEEE, 0,0,0,0,1,8'h33));
    tbl.push_back(mk(0,0,0,1,32'h0,        0,0,0,0,1,8'h33));
    tbl.push_back(mk(0,0,0,0,32'h0,        0,0,0,0,1,8'h33));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,1,0,0,1,8'h33));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,1,1,0,1,8'h34));
    tbl.push_back(mk(1,0,0,0,32'h0,        0,1,0,0,0,8'h00));
    // flush with the second bank loaded, then a fresh matrix
    tbl.push_back(mk(1,0,1,0,32'h44434241, 0,1,0,0,0,8'h00));
    tbl.push_back(mk(1,0,1,1,32'h54535251, 1,1,0,0,1,8'h41));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,0,0,0,1,8'h42));
    tbl.push_back(mk(1,1,0,0,32'h0,        1,0,0,0,1,8'h43));
    tbl.push_back(mk(1,0,1,0,32'hA3A2A1A0, 0,1,0,0,0,8'h00));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,1,0,0,1,8'hA0));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,1,0,0,1,8'hA1));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,1,0,0,1,8'hA2));
    tbl.push_back(mk(1,0,0,1,32'h0,        1,1,1,0,1,8'hA3));
    tbl.push_back(mk(1,0,0,0,32'h0,        0,1,0,0,0,8'h00));

    repeat (2) @(posedge clk_i);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("reset_valid",   -1, 32'(valid_o),   32'd0);
    chk("reset_ready",   -1, 32'(ready_o),   32'd1);
    chk("reset_last",    -1, 32'(last_o),    32'd0);
    chk("reset_dropped", -1, 32'(dropped_o), 32'd0);

    foreach (tbl[i]) begin
      drive(1'b0, tbl[i].en, tbl[i].flush, tbl[i].load, tbl[i].yumi, tbl[i].z);
      chk("valid",   i, 32'(valid_o),   32'(tbl[i].ev));
      chk("ready",   i, 32'(ready_o),   32'(tbl[i].er));
      chk("last",    i, 32'(last_o),    32'(tbl[i].el));
      chk("dropped", i, 32'(dropped_o), 32'(tbl[i].ed));
      if (tbl[i].cd) chk("data", i, 32'(data_o), 32'(tbl[i].d));
    end

    // reset mid-drain with a concurrent load: the load must vanish
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h64636261);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("rst_seq_data0", 100, 32'(data_o), 32'h61);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h74737271);
    chk("rst_seq_data1", 101, 32'(data_o), 32'h62);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_seq_valid",   102, 32'(valid_o),   32'd0);
    chk("rst_seq_ready",   102, 32'(ready_o),   32'd1);
    chk("rst_seq_last",    102, 32'(last_o),    32'd0);
    chk("rst_seq_dropped", 102, 32'(dropped_o), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_seq_still_empty", 103, 32'(valid_o), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h84838281);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
      chk("rst_seq_stream_valid", 104 + k, 32'(valid_o), 32'd1);
      chk("rst_seq_stream_data",  104 + k, 32'(data_o),  32'h81 + 32'(k));
      chk("rst_seq_stream_last",  104 + k, 32'(last_o),  32'(k == 3));
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_seq_done_valid", 108, 32'(valid_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
